// File: rtl/nv_ram_pkg.sv
// nv_ram_pkg: shared constants and helpers for the parametrised two-port RAM
package nv_ram_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // ceil(log2(n)) for n >= 2; used to cross-check the address width
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

endpackage

// File: rtl/nv_ram_array_2p.sv
// nv_ram_array_2p: storage array, synchronous write and range-checked combinational read
module nv_ram_array_2p
    import nv_ram_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 20
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   wa_i,
    input  logic [WIDTH-1:0]          di_i,
    input  logic [clog2(DEPTH)-1:0]   ra_i,
    output logic [WIDTH-1:0]          rd_o
);

    localparam int ADDR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wa_ok;
    logic             ra_ok;

    // addresses past the last entry exist when DEPTH is not a power of two
    assign wa_ok = 32'(wa_i) < DEPTH;
    assign ra_ok = 32'(ra_i) < DEPTH;

    // contents are deliberately not reset so data survives a pipeline reset
    always_ff @(posedge clk) begin
        if (we_i && wa_ok) mem_q[wa_i] <= di_i;
    end

    assign rd_o = ra_ok ? mem_q[ra_i] : '0;

endmodule

// File: rtl/nv_ram_rwsthp_param.sv
// nv_ram_rwsthp_param: 1W/1R RAM with registered read address, bypass, RDW forwarding and error flag
module nv_ram_rwsthp_param
    import nv_ram_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 20,
    parameter int ADDR_W   = 5,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic              re,
    input  logic              ore,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_vld,
    input  logic [ADDR_W-1:0] wa,
    input  logic              we,
    input  logic [WIDTH-1:0]  di,
    input  logic              byp_sel,
    input  logic [WIDTH-1:0]  dbyp,
    input  logic              err_clr,
    output logic              addr_err,
    input  logic [31:0]       pwrbus_ram_pd
);

    if (ADDR_W != clog2(DEPTH)) begin : g_bad_addr_w
        $error("nv_ram_rwsthp_param: ADDR_W must equal clog2(DEPTH)");
    end
    if (WIDTH < 1 || WIDTH > 1024 || DEPTH < 2 || DEPTH > 8192) begin : g_bad_size
        $error("nv_ram_rwsthp_param: WIDTH or DEPTH out of supported range");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("nv_ram_rwsthp_param: RDW_MODE must be 0 or 1");
    end

    logic [ADDR_W-1:0] ra_q, ra_d;
    logic              rd_vld_q, rd_vld_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              addr_err_q, addr_err_d;
    logic [WIDTH-1:0]  arr;
    logic [WIDTH-1:0]  sel;
    logic              wa_ok;
    logic              ra_ok;
    logic              fwd;
    logic              err_set;
    logic              unused_pd;

    // power-down bus is kept only for pin compatibility with the fixed macros
    assign unused_pd = ^pwrbus_ram_pd;

    nv_ram_array_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk  (clk),
        .we_i (we),
        .wa_i (wa),
        .di_i (di),
        .ra_i (ra_q),
        .rd_o (arr)
    );

    assign wa_ok   = 32'(wa) < DEPTH;
    assign ra_ok   = 32'(ra) < DEPTH;
    // write-first mode forwards the incoming write to a read of the same entry
    assign fwd     = (RDW_MODE == RDW_NEW) && we && (wa == ra_q) && wa_ok;
    assign sel     = byp_sel ? dbyp : (fwd ? di : arr);
    assign err_set = (we && !wa_ok) || (re && !ra_ok);

    // next-state for address stage, output stage and sticky error (set beats clear)
    always_comb begin
        ra_d       = re ? ra : ra_q;
        rd_vld_d   = rd_vld_q | re;
        dout_d     = ore ? sel : dout_q;
        dout_vld_d = ore ? (byp_sel | rd_vld_q) : dout_vld_q;
        addr_err_d = err_set | (addr_err_q & ~err_clr);
    end

    // pipeline registers clear asynchronously; array contents are untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q       <= '0;
            rd_vld_q   <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            ra_q       <= ra_d;
            rd_vld_q   <= rd_vld_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_nv_ram_rwsthp_param.sv
// tb_nv_ram_rwsthp_param: directed plus random checks of both RDW modes against a behavioural model
module tb_nv_ram_rwsthp_param;

    localparam int W  = 4;
    localparam int D  = 20;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra = '0, wa = '0;
    logic          re = 1'b0, ore = 1'b0, we = 1'b0, byp_sel = 1'b0, err_clr = 1'b0;
    logic [W-1:0]  di = '0, dbyp = '0;
    logic [31:0]   pd = '0;
    logic [W-1:0]  dout0, dout1;
    logic          vld0, vld1, err0, err1;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mem_m [D];
    int           ra_m  = 0;
    bit           rdv_m = 0;
    logic [W-1:0] dm0   = '0;
    logic [W-1:0] dm1   = '0;
    bit           vm    = 0;
    bit           em    = 0;

    always #5 clk = ~clk;

    nv_ram_rwsthp_param #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp), .err_clr(err_clr),
        .addr_err(err0), .pwrbus_ram_pd(pd)
    );

    nv_ram_rwsthp_param #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .di(di), .byp_sel(byp_sel), .dbyp(dbyp), .err_clr(err_clr),
        .addr_err(err1), .pwrbus_ram_pd(pd)
    );

    function automatic logic [W-1:0] look(input int a);
        return (a < D) ? mem_m[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".dout0"}, dout0, dm0);
        chk({tag, ".dout1"}, dout1, dm1);
        chk({tag, ".vld0"}, W'(vld0), W'(vm));
        chk({tag, ".vld1"}, W'(vld1), W'(vm));
        chk({tag, ".err0"}, W'(err0), W'(em));
        chk({tag, ".err1"}, W'(err1), W'(em));
    endtask

    task automatic model_reset();
        ra_m = 0; rdv_m = 0; dm0 = '0; dm1 = '0; vm = 0; em = 0;
    endtask

    // one clock edge: old-data view before the write, write-first view after it
    task automatic tick(input string tag);
        logic [W-1:0] o, n;
        bit set;
        @(posedge clk);
        o = look(ra_m);
        if (we && int'(wa) < D) mem_m[wa] = di;
        n = look(ra_m);
        set = (we && int'(wa) >= D) || (re && int'(ra) >= D);
        if (rst) model_reset();
        else begin
            if (ore) begin
                dm0 = byp_sel ? dbyp : o;
                dm1 = byp_sel ? dbyp : n;
                vm  = byp_sel | rdv_m;
            end
            if (re) begin
                ra_m  = int'(ra);
                rdv_m = 1;
            end
            em = set | (em & !err_clr);
        end
        #1;
        chk_all(tag);
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        we = 1'b1; wa = AW'(a); di = d;
        tick("wr");
        we = 1'b0;
    endtask

    task automatic rd(input int a);
        re = 1'b1; ra = AW'(a);
        tick("rd_addr");
        re = 1'b0; ore = 1'b1;
        tick("rd_out");
        ore = 1'b0;
    endtask

    initial begin
        pd = $urandom;
        tick("rst0");
        tick("rst1");
        rst = 1'b0;
        chk("rst.dout", dout0, 4'h0);
        chk("rst.vld", W'(vld0), 4'h0);
        chk("rst.err", W'(err0), 4'h0);

        byp_sel = 1'b1; dbyp = 4'hC; ore = 1'b1;
        tick("byp");
        chk("byp.dout", dout0, 4'hC);
        chk("byp.vld", W'(vld1), 4'h1);
        ore = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dbyp = W'($urandom);
            pd = $urandom;
            tick("hold");
        end
        chk("hold.dout", dout1, 4'hC);
        byp_sel = 1'b0;

        for (int i = 0; i < D; i++) wr(i, W'($urandom));
        wr(3, 4'hA);
        wr(19, 4'h5);
        rd(3);
        chk("rd3", dout0, 4'hA);
        chk("rd3.vld", W'(vld0), 4'h1);
        rd(19);
        chk("rd19", dout1, 4'h5);

        wr(7, 4'h1);
        re = 1'b1; ra = 5'd7;
        tick("rdw_addr");
        re = 1'b0;
        we = 1'b1; wa = 5'd7; di = 4'h9; ore = 1'b1;
        tick("rdw_same");
        chk("rdw.old", dout0, 4'h1);
        chk("rdw.new", dout1, 4'h9);
        we = 1'b0;
        tick("rdw_next");
        chk("rdw.next0", dout0, 4'h9);
        chk("rdw.next1", dout1, 4'h9);
        ore = 1'b0;

        wr(25, 4'hF);
        chk("oor.err", W'(err0), 4'h1);
        rd(5);
        rd(21);
        chk("oor.rd", dout0, 4'h0);
        err_clr = 1'b1;
        tick("clr");
        chk("clr.err", W'(err1), 4'h0);
        we = 1'b1; wa = 5'd31; di = 4'h6;
        tick("setwin");
        chk("setwin.err", W'(err0), 4'h1);
        we = 1'b0; err_clr = 1'b0;

        re = 1'b1; ra = 5'd19; ore = 1'b1;
        tick("pre_arst");
        re = 1'b0; ore = 1'b0;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("arst");
        chk("arst.dout", dout0, 4'h0);
        tick("arst_hold");
        rst = 1'b0;
        rd(3);
        chk("arst.keep", dout0, 4'hA);

        for (int i = 0; i < 400; i++) begin
            re      = ($urandom_range(0, 1) == 1);
            ore     = ($urandom_range(0, 2) != 0);
            we      = ($urandom_range(0, 1) == 1);
            byp_sel = ($urandom_range(0, 4) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            ra      = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, D - 1));
            wa      = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, D - 1));
            if ($urandom_range(0, 3) == 0) wa = ra_m[AW-1:0];
            di      = W'($urandom);
            dbyp    = W'($urandom);
            pd      = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
